skill_controller: RTL

SKILL_CONTROLLER -- requirements
Module: skill_controller

---
 rtl/skill_controller_pkg.sv | 33 +++
 rtl/skill_controller_if.sv | 24 ++
 rtl/skill_timer.sv | 75 +++++++
 rtl/skill_controller.sv | 104 ++++++++++
 4 files changed

// File: rtl/skill_controller_pkg.sv
// Shared game definitions: skill indices, skill FSM encoding, default timings.
package skill_controller_pkg;

    localparam int NUM_SKILLS = 3;
    localparam int SKILL_J    = 0;
    localparam int SKILL_K    = 1;
    localparam int SKILL_L    = 2;

    localparam int POINTS_INIT_DEF = 3;
    localparam int DUR_J_DEF       = 100;
    localparam int DUR_K_DEF       = 100;
    localparam int DUR_L_DEF       = 60;
    localparam int COOLDOWN_DEF    = 40;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_COOL   = 2'd2
    } skill_state_t;

    // Thermometer fill for led[15:13]: the MSB lights first.
    function automatic logic [2:0] points_to_led(input logic [1:0] points);
        logic [2:0] led;
        case (points)
            2'd0:    led = 3'b000;
            2'd1:    led = 3'b100;
            2'd2:    led = 3'b110;
            default: led = 3'b111;
        endcase
        return led;
    endfunction

endpackage

// File: rtl/skill_controller_if.sv
// Game-side signals of the skill controller: stage/key/life inputs and skill outputs.
interface skill_controller_if;

    logic       in_stage;
    logic       key_j;
    logic       key_k;
    logic       key_l;
    logic       life_lost;
    logic [2:0] skill_start;
    logic [2:0] skill_active;
    logic [1:0] skill_point;
    logic [2:0] led_skill;

    modport master (
        output in_stage, key_j, key_k, key_l, life_lost,
        input  skill_start, skill_active, skill_point, led_skill
    );

    modport slave (
        input  in_stage, key_j, key_k, key_l, life_lost,
        output skill_start, skill_active, skill_point, led_skill
    );

endinterface

// File: rtl/skill_timer.sv
// One skill: IDLE -> ACTIVE (DUR ticks) -> COOL (COOLDOWN ticks) -> IDLE.
//
// state     | meaning
// ST_IDLE   | skill usable, counter held at 0
// ST_ACTIVE | skill in effect, counter runs DUR-1 down to 0
// ST_COOL   | skill unusable, counter runs COOLDOWN-1 down to 0
module skill_timer
    import skill_controller_pkg::*;
#(
    parameter int DUR      = 100,
    parameter int COOLDOWN = 40
) (
    input  logic clk_22,
    input  logic rst,
    input  logic start,
    input  logic abort,
    input  logic clear,
    output logic idle,
    output logic active
);

    localparam logic [7:0] DUR_M1  = 8'(DUR - 1);
    localparam logic [7:0] COOL_M1 = 8'(COOLDOWN - 1);

    skill_state_t state;
    logic [7:0]   count;

    // Only used by the arbiter inside the controller, never a top-level output.
    assign idle = (state == ST_IDLE);

    // Skill FSM with terminal-count down-counter; active is kept as its own flop.
    always_ff @(posedge clk_22 or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            count  <= 8'd0;
            active <= 1'b0;
        end else if (clear) begin
            state  <= ST_IDLE;
            count  <= 8'd0;
            active <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_ACTIVE;
                        count  <= DUR_M1;
                        active <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (abort || count == 8'd0) begin
                        state  <= ST_COOL;
                        count  <= COOL_M1;
                        active <= 1'b0;
                    end else begin
                        count <= count - 8'd1;
                    end
                end
                ST_COOL: begin
                    if (count == 8'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        count <= count - 8'd1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    count  <= 8'd0;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/skill_controller.sv
// Skill controller: arbitrates key presses (J > K > L), spends skill points,
// and drives three skill timers. All outputs come straight from flops.
module skill_controller
    import skill_controller_pkg::*;
#(
    parameter int POINTS_INIT = POINTS_INIT_DEF,
    parameter int DUR_J       = DUR_J_DEF,
    parameter int DUR_K       = DUR_K_DEF,
    parameter int DUR_L       = DUR_L_DEF,
    parameter int COOLDOWN    = COOLDOWN_DEF
) (
    input  logic           clk_22,
    input  logic           rst,
    skill_controller_if.slave bus
);

    localparam logic [1:0] POINTS_RST = 2'(POINTS_INIT);

    logic [NUM_SKILLS-1:0] press;
    logic [NUM_SKILLS-1:0] idle;
    logic [NUM_SKILLS-1:0] active;
    logic [NUM_SKILLS-1:0] grant;
    logic [NUM_SKILLS-1:0] skill_start_q;
    logic [1:0]            skill_point_q;
    logic [1:0]            skill_point_nxt;
    logic [2:0]            led_skill_q;
    logic                  can_accept;

    assign press = {bus.key_l, bus.key_k, bus.key_j};

    // A point is spendable only in play, outside a life-lost cycle, with points left.
    assign can_accept = bus.in_stage && !bus.life_lost && (skill_point_q != 2'd0);

    // Fixed-priority grant among idle pressed skills; losers are simply dropped.
    always_comb begin
        grant = '0;
        if (can_accept) begin
            if (press[SKILL_J] && idle[SKILL_J]) begin
                grant[SKILL_J] = 1'b1;
            end else if (press[SKILL_K] && idle[SKILL_K]) begin
                grant[SKILL_K] = 1'b1;
            end else if (press[SKILL_L] && idle[SKILL_L]) begin
                grant[SKILL_L] = 1'b1;
            end
        end
    end

    // Grant implies skill_point_q > 0, so the decrement can never wrap.
    always_comb begin
        skill_point_nxt = skill_point_q;
        if (grant != '0) begin
            skill_point_nxt = skill_point_q - 2'd1;
        end
    end

    // Registered start pulse, point counter and LED thermometer.
    always_ff @(posedge clk_22 or posedge rst) begin
        if (rst) begin
            skill_start_q <= '0;
            skill_point_q <= POINTS_RST;
            led_skill_q   <= points_to_led(POINTS_RST);
        end else begin
            skill_start_q <= grant;
            skill_point_q <= skill_point_nxt;
            led_skill_q   <= points_to_led(skill_point_nxt);
        end
    end

    skill_timer #(.DUR(DUR_J), .COOLDOWN(COOLDOWN)) u_timer_j (
        .clk_22 (clk_22),
        .rst    (rst),
        .start  (grant[SKILL_J]),
        .abort  (bus.life_lost),
        .clear  (!bus.in_stage),
        .idle   (idle[SKILL_J]),
        .active (active[SKILL_J])
    );

    skill_timer #(.DUR(DUR_K), .COOLDOWN(COOLDOWN)) u_timer_k (
        .clk_22 (clk_22),
        .rst    (rst),
        .start  (grant[SKILL_K]),
        .abort  (bus.life_lost),
        .clear  (!bus.in_stage),
        .idle   (idle[SKILL_K]),
        .active (active[SKILL_K])
    );

    skill_timer #(.DUR(DUR_L), .COOLDOWN(COOLDOWN)) u_timer_l (
        .clk_22 (clk_22),
        .rst    (rst),
        .start  (grant[SKILL_L]),
        .abort  (bus.life_lost),
        .clear  (!bus.in_stage),
        .idle   (idle[SKILL_L]),
        .active (active[SKILL_L])
    );

    assign bus.skill_start  = skill_start_q;
    assign bus.skill_active = active;
    assign bus.skill_point  = skill_point_q;
    assign bus.led_skill    = led_skill_q;

endmodule
